// File: rtl/sad_search_ctrl.sv
// Motion-estimation search scheduler: launches the SAD unit once per candidate,
// tracks the minimum result and its index, exits early below a threshold.
module sad_search_ctrl #(
    parameter int NUM_CAND = 16,
    parameter int CAND_W   = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       thr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       best_sad_o,
    output logic [CAND_W-1:0] best_idx_o,
    output logic [CAND_W-1:0] cand_o,
    output logic              sad_enb_o,
    input  logic              sad_busy_i,
    input  logic [31:0]       sad_dt_i
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        CMP,
        FINISH
    } state_t;

    state_t            state;
    logic [TCNT_W-1:0] tcnt;
    logic              first;

    // A zero threshold disables the early exit.
    function automatic logic below_thr(input logic [31:0] dt, input logic [31:0] thr);
        return (thr != 32'd0) && (dt < thr);
    endfunction

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state      <= IDLE;
            tcnt       <= '0;
            first      <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            sad_enb_o  <= 1'b0;
            cand_o     <= '0;
            best_sad_o <= '0;
            best_idx_o <= '0;
        end else begin
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            sad_enb_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= LAUNCH;
                        busy_o     <= 1'b1;
                        sad_enb_o  <= 1'b1;
                        cand_o     <= '0;
                        best_sad_o <= '1;
                        best_idx_o <= '0;
                        first      <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
                    tcnt  <= '0;
                end
                WAIT_BUSY: begin
                    if (sad_busy_i) begin
                        state <= WAIT_DONE;
                    end else if (tcnt == TCNT_LAST) begin
                        // SAD unit never acknowledged: abort, keeping the best so far.
                        state  <= FINISH;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!sad_busy_i) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    // Strict compare so ties keep the earlier (lower) index.
                    if (first || (sad_dt_i < best_sad_o)) begin
                        best_sad_o <= sad_dt_i;
                        best_idx_o <= cand_o;
                        first      <= 1'b0;
                    end
                    if ((cand_o == LAST_CAND) || below_thr(sad_dt_i, thr_i)) begin
                        state  <= FINISH;
                        done_o <= 1'b1;
                    end else begin
                        cand_o    <= cand_o + 1'b1;
                        state     <= LAUNCH;
                        sad_enb_o <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Scoreboard bench for sad_search_ctrl: a behavioural SAD responder, a search-level
// reference model feeding an expectation queue, and an independent output monitor.
module tb_sad_search_ctrl;

    localparam int NUM_CAND = 4;
    localparam int CAND_W   = 2;
    localparam int TIMEOUT  = 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [31:0]       thr_i = '0;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [31:0]       best_sad_o;
    logic [CAND_W-1:0] best_idx_o;
    logic [CAND_W-1:0] cand_o;
    logic              sad_enb_o;
    logic              sad_busy_i = 1'b0;
    logic [31:0]       sad_dt_i = '0;

    sad_search_ctrl #(.NUM_CAND(NUM_CAND), .CAND_W(CAND_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .thr_i      (thr_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .best_sad_o (best_sad_o),
        .best_idx_o (best_idx_o),
        .cand_o     (cand_o),
        .sad_enb_o  (sad_enb_o),
        .sad_busy_i (sad_busy_i),
        .sad_dt_i   (sad_dt_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sad;
        logic [1:0]  idx;
        logic        err;
        int          nenb;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] res [NUM_CAND];
    int          hang_cand = -1;
    int          force_dly = 0;
    int          force_run = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          done_seen = 0;
    int          enb_cnt = 0;
    int          last_enb = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Search-level reference: walk the candidates in order as the rules describe.
    function automatic exp_t predict(input logic [31:0] thr);
        exp_t e;
        bit   found = 0;
        e.sad  = 32'hFFFF_FFFF;
        e.idx  = 0;
        e.err  = 0;
        e.nenb = 0;
        for (int i = 0; i < NUM_CAND; i++) begin
            e.nenb = i + 1;
            if (i == hang_cand) begin
                e.err = 1;
                break;
            end
            if (!found || res[i] < e.sad) begin
                e.sad = res[i];
                e.idx = 2'(i);
            end
            found = 1;
            if (thr != 0 && res[i] < thr) break;
        end
        return e;
    endfunction

    // Behavioural SAD unit: busy rises 1..3 cycles after enable, stays up 1..4 cycles.
    initial begin
        int mode = 0;
        int dly = 0;
        int run = 0;
        logic [31:0] r = '0;
        forever begin
            @(negedge clk);
            case (mode)
                0: if (sad_enb_o && int'(cand_o) != hang_cand) begin
                    r    = res[cand_o];
                    dly  = (force_dly != 0) ? force_dly : $urandom_range(1, 3);
                    run  = (force_run != 0) ? force_run : $urandom_range(1, 4);
                    mode = 1;
                end
                1: begin
                    dly--;
                    if (dly == 0) begin
                        sad_busy_i = 1'b1;
                        sad_dt_i   = $urandom;
                        mode       = 2;
                    end
                end
                default: begin
                    run--;
                    if (run == 0) begin
                        sad_busy_i = 1'b0;
                        sad_dt_i   = r;
                        mode       = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: checks every enable pulse and every completion against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                enb_cnt = 0;
            end else begin
                if (sad_enb_o) begin
                    chk("enb_cand", 64'(cand_o), 64'(enb_cnt));
                    enb_cnt++;
                    last_enb = cyc;
                end
                if (err_o && !done_o) chk("err_without_done", 64'(err_o), 64'd0);
                if (done_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(done_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("best_sad", 64'(best_sad_o), 64'(e.sad));
                        chk("best_idx", 64'(best_idx_o), 64'(e.idx));
                        chk("err", 64'(err_o), 64'(e.err));
                        chk("enb_pulses", 64'(enb_cnt), 64'(e.nenb));
                        chk("busy_at_done", 64'(busy_o), 64'd1);
                        if (e.err) begin
                            chk("timeout_latency_ok",
                                64'((cyc - last_enb >= TIMEOUT) && (cyc - last_enb <= TIMEOUT + 2)),
                                64'd1);
                        end
                    end
                    enb_cnt = 0;
                    done_seen++;
                end
            end
        end
    end

    task automatic wait_done(input int base);
        bit got = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #1;
            if (done_seen > base) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("done_within_budget", 64'd0, 64'd1);
    endtask

    // Returns at the negedge of the IDLE cycle following done_o.
    task automatic run_search(input logic [31:0] thr, input bit hold);
        int base = done_seen;
        thr_i = thr;
        exp_q.push_back(predict(thr));
        start_i = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        wait_done(base);
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_res(input logic [31:0] a, b, c, d);
        res[0] = a; res[1] = b; res[2] = c; res[3] = d;
    endtask

    initial begin
        for (int i = 0; i < NUM_CAND; i++) res[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_enb", 64'(sad_enb_o), 64'd0);
        chk("rst_cand", 64'(cand_o), 64'd0);
        chk("rst_best_sad", 64'(best_sad_o), 64'd0);
        chk("rst_best_idx", 64'(best_idx_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        set_res(50, 20, 30, 20);
        run_search(0, 0);
        set_res(100, 40, 9, 70);
        run_search(10, 0);
        set_res(5, 7, 8, 9);
        hang_cand = 1;
        run_search(0, 0);
        hang_cand = -1;

        set_res('1, '1, '1, '1);
        run_search(0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("no_restart_after_hold", 64'(busy_o), 64'd0);

        // Reset while cand 2 is in WAIT_DONE: search abandoned, no done_o.
        set_res(60, 50, 40, 30);
        force_dly = 1;
        force_run = 8;
        thr_i = 0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        begin
            bit seen = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (sad_enb_o && cand_o == 2'd2) begin
                    seen = 1;
                    break;
                end
            end
            chk("reached_cand2", 64'(seen), 64'd1);
        end
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_cand", 64'(cand_o), 64'd0);
        chk("midrst_best_sad", 64'(best_sad_o), 64'd0);
        exp_q.delete();
        rst_i = 1'b0;
        force_dly = 0;
        force_run = 0;
        repeat (15) @(negedge clk);
        set_res(50, 20, 30, 20);
        run_search(0, 0);

        // Back-to-back: second search must not inherit the first one's minimum.
        set_res(3, 1, 2, 4);
        run_search(0, 0);
        set_res(10, 20, 30, 40);
        run_search(0, 0);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NUM_CAND; i++)
                res[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            hang_cand = ($urandom_range(0, 5) < 4) ? -1 : int'($urandom_range(0, NUM_CAND - 1));
            run_search(($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(0, 40)), 0);
        end
        hang_cand = -1;

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
